// File: rtl/mips_core.sv
// Single-cycle MIPS32 subset core: fetch, decode, execute and retire one instruction per clock.
// Instruction and data memories are external and combinational.
module mips_core #(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned DATA_MEM_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [PC_WIDTH-1:0]       pc,
  input  logic [INSTR_WIDTH-1:0]    instr,
  output logic                      memwrite,
  output logic [DATA_MEM_WIDTH-1:0] memaddr,
  output logic [DATA_MEM_WIDTH-1:0] writedata,
  input  logic [DATA_MEM_WIDTH-1:0] readdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_src_e;

  logic [PC_WIDTH-1:0] r_pc;
  logic [XLEN-1:0]     r_regs [NREG];

  logic [XLEN-1:0] w_instr;
  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [RA_W-1:0] w_rs;
  logic [RA_W-1:0] w_rt;
  logic [RA_W-1:0] w_rd;
  logic [4:0]      w_shamt;
  logic [15:0]     w_imm;
  logic [25:0]     w_jaddr;

  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_imm_se;
  logic [XLEN-1:0] w_imm_ze;
  logic [XLEN-1:0] w_pc32;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_j_target;

  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_wd;
  logic [RA_W-1:0] w_wa;
  logic            w_we;
  logic            w_mw;
  wb_src_e         w_wb_src;

  // Field extraction and operand fetch; $0 always reads as zero
  always_comb begin
    w_instr     = XLEN'(instr);
    w_op        = w_instr[31:26];
    w_rs        = w_instr[25:21];
    w_rt        = w_instr[20:16];
    w_rd        = w_instr[15:11];
    w_shamt     = w_instr[10:6];
    w_funct     = w_instr[5:0];
    w_imm       = w_instr[15:0];
    w_jaddr     = w_instr[25:0];
    w_rs_val    = (w_rs == '0) ? '0 : r_regs[w_rs];
    w_rt_val    = (w_rt == '0) ? '0 : r_regs[w_rt];
    w_imm_se    = {{16{w_imm[15]}}, w_imm};
    w_imm_ze    = {16'h0000, w_imm};
    w_pc32      = XLEN'(r_pc);
    w_pc_plus4  = w_pc32 + 32'd4;
    w_br_target = w_pc_plus4 + (w_imm_se << 2);
    w_j_target  = {w_pc_plus4[31:28], w_jaddr, 2'b00};
  end

  // Decode and execute; anything not listed falls through as a NOP
  always_comb begin
    w_alu     = '0;
    w_we      = 1'b0;
    w_wa      = w_rt;
    w_mw      = 1'b0;
    w_next_pc = w_pc_plus4;
    w_wb_src  = WB_ALU;
    case (w_op)
      OP_RTYPE: begin
        w_wa = w_rd;
        case (w_funct)
          FN_ADD:  begin w_alu = w_rs_val + w_rt_val;    w_we = 1'b1; end
          FN_SUB:  begin w_alu = w_rs_val - w_rt_val;    w_we = 1'b1; end
          FN_AND:  begin w_alu = w_rs_val & w_rt_val;    w_we = 1'b1; end
          FN_OR:   begin w_alu = w_rs_val | w_rt_val;    w_we = 1'b1; end
          FN_XOR:  begin w_alu = w_rs_val ^ w_rt_val;    w_we = 1'b1; end
          FN_NOR:  begin w_alu = ~(w_rs_val | w_rt_val); w_we = 1'b1; end
          FN_SLT:  begin w_alu = XLEN'($signed(w_rs_val) < $signed(w_rt_val)); w_we = 1'b1; end
          FN_SLTU: begin w_alu = XLEN'(w_rs_val < w_rt_val); w_we = 1'b1; end
          FN_SLL:  begin w_alu = w_rt_val << w_shamt;    w_we = 1'b1; end
          FN_SRL:  begin w_alu = w_rt_val >> w_shamt;    w_we = 1'b1; end
          FN_JR:   w_next_pc = w_rs_val;
          default: ;
        endcase
      end
      OP_ADDI: begin w_alu = w_rs_val + w_imm_se; w_we = 1'b1; end
      OP_SLTI: begin w_alu = XLEN'($signed(w_rs_val) < $signed(w_imm_se)); w_we = 1'b1; end
      OP_ANDI: begin w_alu = w_rs_val & w_imm_ze; w_we = 1'b1; end
      OP_ORI:  begin w_alu = w_rs_val | w_imm_ze; w_we = 1'b1; end
      OP_LUI:  begin w_alu = {w_imm, 16'h0000};   w_we = 1'b1; end
      OP_LW:   begin w_alu = w_rs_val + w_imm_se; w_we = 1'b1; w_wb_src = WB_MEM; end
      OP_SW:   begin w_alu = w_rs_val + w_imm_se; w_mw = 1'b1; end
      OP_BEQ:  begin
        w_alu = w_rs_val - w_rt_val;
        if (w_rs_val == w_rt_val) w_next_pc = w_br_target;
      end
      OP_BNE:  begin
        w_alu = w_rs_val - w_rt_val;
        if (w_rs_val != w_rt_val) w_next_pc = w_br_target;
      end
      OP_J:    w_next_pc = w_j_target;
      OP_JAL:  begin
        w_next_pc = w_j_target;
        w_we      = 1'b1;
        w_wa      = RA_W'(31);
        w_wb_src  = WB_LINK;
      end
      default: ;
    endcase
    case (w_wb_src)
      WB_MEM:  w_wd = XLEN'(readdata);
      WB_LINK: w_wd = w_pc_plus4;
      default: w_wd = w_alu;
    endcase
  end

  // Program counter and register file; reset wins over any retiring instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= PC_WIDTH'(w_next_pc);
      if (w_we && (w_wa != '0)) r_regs[w_wa] <= w_wd;
    end
  end

  assign pc        = r_pc;
  assign memwrite  = w_mw & rst_n;
  assign memaddr   = DATA_MEM_WIDTH'(w_alu);
  assign writedata = DATA_MEM_WIDTH'(w_rt_val);

endmodule

// File: tb/tb_mips_core.sv
// Directed bench for mips_core: a hand-assembled program with expected pc trace,
// expected store stream, and reset behaviour.
module tb_mips_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic [31:0] imem [128];
  logic [31:0] dmem [32];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_pc   [$];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  mips_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .instr     (instr),
    .memwrite  (memwrite),
    .memaddr   (memaddr),
    .writedata (writedata),
    .readdata  (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr    = imem[pc[8:2]];
  assign readdata = dmem[memaddr[6:2]];

  always @(posedge clk) if (memwrite) dmem[memaddr[6:2]] <= writedata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every store seen outside reset must match the next expected store
  always @(negedge clk) begin
    if (rst_n && memwrite) begin
      if (exp_addr.size() == 0) begin
        check("sw_unexpected", memaddr, 32'hFFFF_FFFF);
      end else begin
        check("sw_addr", memaddr, exp_addr.pop_front());
        check("sw_data", writedata, exp_data.pop_front());
      end
    end
  end

  task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < 32; i++) dmem[i] = 32'h0;

    imem[0]  = 32'h20020005; // addi $2,$0,5
    imem[1]  = 32'h2003FFFD; // addi $3,$0,-3
    imem[2]  = 32'h00432020; // add  $4,$2,$3
    imem[3]  = 32'h0062282A; // slt  $5,$3,$2
    imem[4]  = 32'h10000002; // beq  $0,$0,+2 -> 0x1C
    imem[5]  = 32'h20040063; // skipped
    imem[6]  = 32'h20050063; // skipped
    imem[7]  = 32'h14000002; // bne  $0,$0,+2 not taken
    imem[8]  = 32'h0C000040; // jal  0x100
    imem[9]  = 32'hAC04000C; // sw   $4,12($0)
    imem[10] = 32'hAC050010; // sw   $5,16($0)
    imem[11] = 32'h20020055; // addi $2,$0,0x55
    imem[12] = 32'hAC020008; // sw   $2,8($0)
    imem[13] = 32'h8C060008; // lw   $6,8($0)
    imem[14] = 32'hAC060014; // sw   $6,20($0)
    imem[15] = 32'h20000007; // addi $0,$0,7
    imem[16] = 32'h00003820; // add  $7,$0,$0
    imem[17] = 32'hAC000018; // sw   $0,24($0)
    imem[18] = 32'hAC07001C; // sw   $7,28($0)
    imem[19] = 32'h3C081234; // lui  $8,0x1234
    imem[20] = 32'h35088001; // ori  $8,$8,0x8001
    imem[21] = 32'hAC080020; // sw   $8,32($0)
    imem[22] = 32'h0043482B; // sltu $9,$2,$3
    imem[23] = 32'h00435022; // sub  $10,$2,$3
    imem[24] = 32'h00405827; // nor  $11,$2,$0
    imem[25] = 32'h00026100; // sll  $12,$2,4
    imem[26] = 32'h00036F02; // srl  $13,$3,28
    imem[27] = 32'h306EFF0F; // andi $14,$3,0xFF0F
    imem[28] = 32'h286FFFFE; // slti $15,$3,-2
    imem[29] = 32'h00488026; // xor  $16,$2,$8
    imem[30] = 32'hAC090024; // sw   $9..$16 at 36..64
    imem[31] = 32'hAC0A0028;
    imem[32] = 32'hAC0B002C;
    imem[33] = 32'hAC0C0030;
    imem[34] = 32'hAC0D0034;
    imem[35] = 32'hAC0E0038;
    imem[36] = 32'hAC0F003C;
    imem[37] = 32'hAC100040;
    imem[38] = 32'hFC000000; // undefined opcode: NOP
    imem[39] = 32'h08000027; // j    0x9C (self loop)
    imem[64] = 32'hAC1F0000; // sw   $31,0($0)
    imem[65] = 32'h03E00008; // jr   $31

    exp_store(32'd0,  32'h24);
    exp_store(32'd12, 32'd2);
    exp_store(32'd16, 32'd1);
    exp_store(32'd8,  32'h55);
    exp_store(32'd20, 32'h55);
    exp_store(32'd24, 32'h0);
    exp_store(32'd28, 32'h0);
    exp_store(32'd32, 32'h12348001);
    exp_store(32'd36, 32'd1);
    exp_store(32'd40, 32'h58);
    exp_store(32'd44, 32'hFFFFFFAA);
    exp_store(32'd48, 32'h550);
    exp_store(32'd52, 32'hF);
    exp_store(32'd56, 32'hFF0D);
    exp_store(32'd60, 32'd1);
    exp_store(32'd64, 32'h12348054);

    exp_pc = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h104};
    for (int a = 32'h24; a <= 32'h9C; a += 4) exp_pc.push_back(32'(a));
    exp_pc.push_back(32'h9C);
    exp_pc.push_back(32'h9C);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", pc, 32'h0);
    check("reset_memwrite", {31'b0, memwrite}, 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < exp_pc.size(); k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("pc_step%0d", k), pc, exp_pc[k]);
      if (k < 2) check("early_memwrite", {31'b0, memwrite}, 32'h0);
    end
    check("sw_count", 32'(exp_addr.size()), 32'h0);
    check("dmem_lw_src", dmem[2], 32'h55);

    // Reset in the middle of a jump loop, with a store presented while reset is held
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    imem[0] = 32'hAC020008;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_memwrite", {31'b0, memwrite}, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("midrst_reg%0d", i), dut.r_regs[i], 32'h0);
    imem[0] = 32'h20020005;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_pc", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
